// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port program/data memory between the CPU control
// FSM and the program loader/debug port. Each side runs a req/gnt/done handshake and gets
// one access per grant; o_cpu_stall lets the control FSM hold while memory is busy.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration on contention;
// without it the loader has fixed priority over the CPU.
module mem_port_arbiter #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    // CPU control FSM side
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_gnt,
    output logic          o_cpu_done,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_stall,
    // Loader/debug side
    input  logic          i_ldr_req,
    input  logic          i_ldr_we,
    input  logic [AW-1:0] i_ldr_addr,
    input  logic [DW-1:0] i_ldr_wdata,
    output logic          o_ldr_gnt,
    output logic          o_ldr_done,
    output logic [DW-1:0] o_ldr_rdata,
    output logic          o_ldr_stall,
    // Memory port
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    // Wait-counter load value; MEM_LAT is limited to 1..7 so 3 bits suffice.
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e        r_state;
    state_e        w_state_next;

    logic          r_owner_cpu;   // 1: CPU owns the current transaction, 0: loader
    logic          r_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [2:0]    r_cnt;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_ldr_rdata;

    logic          w_any_req;
    logic          w_start;
    logic          w_sel_cpu;

    assign w_any_req = i_cpu_req | i_ldr_req;
    assign w_start   = (r_state == StIdle) & w_any_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_cpu;  // last contention winner; resets to loader so the CPU wins first

    // Remember the winner of each contended arbitration.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_cpu <= 1'b0;
        end else if (w_start && i_cpu_req && i_ldr_req) begin
            r_last_cpu <= w_sel_cpu;
        end
    end

    assign w_sel_cpu = i_cpu_req & (~i_ldr_req | ~r_last_cpu);
`else
    // Loader always wins; the CPU can starve while the loader keeps requesting.
    assign w_sel_cpu = i_cpu_req & ~i_ldr_req;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: requests are only looked at in StIdle.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_next = StAccess;
                end
            end
            StAccess: begin
                if (r_we || (MEM_LAT == 1)) begin
                    w_state_next = StDone;
                end else begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (r_cnt == 3'd1) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Command capture at grant, latency counter, and read-data capture at the end of DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_owner_cpu <= 1'b0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cnt       <= 3'd0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            if (w_start) begin
                r_owner_cpu <= w_sel_cpu;
                r_we        <= w_sel_cpu ? i_cpu_we    : i_ldr_we;
                r_mem_addr  <= w_sel_cpu ? i_cpu_addr  : i_ldr_addr;
                r_mem_wdata <= w_sel_cpu ? i_cpu_wdata : i_ldr_wdata;
            end
            if (r_state == StAccess) begin
                r_cnt <= LAT_M1;
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if ((r_state == StDone) && !r_we) begin
                if (r_owner_cpu) begin
                    r_cpu_rdata <= i_mem_rdata;
                end else begin
                    r_ldr_rdata <= i_mem_rdata;
                end
            end
        end
    end

    // Outputs: grant/done decoded from state; read data is passed through during the
    // DONE cycle (memory data is only valid then) and held from the capture register after.
    always_comb begin
        o_cpu_gnt   = (r_state != StIdle) & r_owner_cpu;
        o_ldr_gnt   = (r_state != StIdle) & ~r_owner_cpu;
        o_cpu_done  = (r_state == StDone) & r_owner_cpu;
        o_ldr_done  = (r_state == StDone) & ~r_owner_cpu;
        o_cpu_stall = i_cpu_req & ~o_cpu_done;
        o_ldr_stall = i_ldr_req & ~o_ldr_done;
        o_cpu_rdata = (o_cpu_done && !r_we) ? i_mem_rdata : r_cpu_rdata;
        o_ldr_rdata = (o_ldr_done && !r_we) ? i_mem_rdata : r_ldr_rdata;
        o_mem_en    = (r_state == StAccess);
        o_mem_we    = (r_state == StAccess) & r_we;
        o_mem_addr  = r_mem_addr;
        o_mem_wdata = r_mem_wdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level reference model (per-requester command queues,
// reference memory image, arbitration rule and fixed latencies) compared every cycle
// against a MEM_LAT=1 instance; a MEM_LAT=3 instance covers the WAIT path and reset.
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 1;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // MEM_LAT=1 instance
    logic       cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
    logic [7:0] cpu_addr = 8'h0, cpu_wdata = 8'h0, ldr_addr = 8'h0, ldr_wdata = 8'h0;
    logic       cpu_gnt, cpu_done, cpu_stall, ldr_gnt, ldr_done, ldr_stall;
    logic [7:0] cpu_rdata, ldr_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    // MEM_LAT=3 instance (CPU side only used)
    logic       b_cpu_req = 1'b0, b_cpu_we = 1'b0, b_ldr_req = 1'b0, b_ldr_we = 1'b0;
    logic [7:0] b_cpu_addr = 8'h0, b_cpu_wdata = 8'h0, b_ldr_addr = 8'h0, b_ldr_wdata = 8'h0;
    logic       b_cpu_gnt, b_cpu_done, b_cpu_stall, b_ldr_gnt, b_ldr_done, b_ldr_stall;
    logic [7:0] b_cpu_rdata, b_ldr_rdata;
    logic       b_mem_en, b_mem_we;
    logic [7:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(LAT)) u_dut (
        .CLK(CLK), .RST(RST),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_gnt(cpu_gnt), .o_cpu_done(cpu_done),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr),
        .i_ldr_wdata(ldr_wdata), .o_ldr_gnt(ldr_gnt), .o_ldr_done(ldr_done),
        .o_ldr_rdata(ldr_rdata), .o_ldr_stall(ldr_stall),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(3)) u_dut3 (
        .CLK(CLK), .RST(RST),
        .i_cpu_req(b_cpu_req), .i_cpu_we(b_cpu_we), .i_cpu_addr(b_cpu_addr),
        .i_cpu_wdata(b_cpu_wdata), .o_cpu_gnt(b_cpu_gnt), .o_cpu_done(b_cpu_done),
        .o_cpu_rdata(b_cpu_rdata), .o_cpu_stall(b_cpu_stall),
        .i_ldr_req(b_ldr_req), .i_ldr_we(b_ldr_we), .i_ldr_addr(b_ldr_addr),
        .i_ldr_wdata(b_ldr_wdata), .o_ldr_gnt(b_ldr_gnt), .o_ldr_done(b_ldr_done),
        .o_ldr_rdata(b_ldr_rdata), .o_ldr_stall(b_ldr_stall),
        .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 29 + 7) & 255);
    endfunction

    // Memories: data is driven only in the exact cycle it is valid, zero otherwise.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] rd1, p0, p1, p2;
    always @(posedge CLK) begin
        rd1 <= 8'h00;
        p0  <= 8'h00;
        p1  <= p0;
        p2  <= p1;
        if (RST) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= init_val(i);
                mem3[i] <= init_val(i);
            end
        end
        if (mem_en) begin
            if (mem_we) mem1[mem_addr] <= mem_wdata;
            else        rd1 <= mem1[mem_addr];
        end
        if (b_mem_en) begin
            if (b_mem_we) mem3[b_mem_addr] <= b_mem_wdata;
            else          p0 <= mem3[b_mem_addr];
        end
    end
    assign mem_rdata   = rd1;
    assign b_mem_rdata = p2;

    // Reference model state
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ref_mem [256];
    cmd_t       cq[$];
    cmd_t       lq[$];
    bit         m_last_cpu = 1'b0;
    logic [7:0] m_cpu_rd = 8'h00;
    logic [7:0] m_ldr_rd = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = 8'($urandom_range(0, 15));
        c.wdata = 8'($urandom);
        return c;
    endfunction

    function automatic cmd_t mk(input logic we, input logic [7:0] a, input logic [7:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        m_last_cpu = 1'b0;
        m_cpu_rd   = 8'h00;
        m_ldr_rd   = 8'h00;
    endtask

    // Request drivers; when a side is not requesting its command lines carry junk.
    task automatic drive(input bit drop, input bit busy, input bit own_cpu);
        if (cq.size() != 0 && !(drop && busy && own_cpu)) begin
            cpu_req = 1'b1; cpu_we = cq[0].we; cpu_addr = cq[0].addr; cpu_wdata = cq[0].wdata;
        end else begin
            cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 8'($urandom);
            cpu_wdata = 8'($urandom);
        end
        if (lq.size() != 0) begin
            ldr_req = 1'b1; ldr_we = lq[0].we; ldr_addr = lq[0].addr; ldr_wdata = lq[0].wdata;
        end else begin
            ldr_req = 1'b0; ldr_we = 1'($urandom); ldr_addr = 8'($urandom);
            ldr_wdata = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0; b_cpu_req = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("rst_cpu_gnt", cpu_gnt, 0);     chk("rst_ldr_gnt", ldr_gnt, 0);
        chk("rst_cpu_done", cpu_done, 0);   chk("rst_ldr_done", ldr_done, 0);
        chk("rst_mem_en", mem_en, 0);       chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_ldr_rdata", ldr_rdata, 0);
        chk("rst_b_gnt", b_cpu_gnt, 0);     chk("rst_b_mem_en", b_mem_en, 0);
    endtask

    // Serve both queues to completion, comparing every cycle against the model.
    task automatic run_round(input bit cpu_drop);
        int   cyc, t_start, t_lat;
        bit   busy, own_cpu, in_txn, e_done, e_men;
        cmd_t cur;
        cyc = 0; t_start = 0; t_lat = 0; busy = 0; own_cpu = 0;
        cur = mk(1'b0, 8'h00, 8'h00);
        @(posedge CLK); #1;
        drive(cpu_drop, busy, own_cpu);
        while ((cq.size() != 0 || lq.size() != 0 || busy) && cyc < 200) begin
            @(negedge CLK);
            in_txn = busy && (cyc > t_start) && (cyc <= t_start + t_lat);
            e_done = busy && (cyc == t_start + t_lat);
            e_men  = busy && (cyc == t_start + 1);
            chk("cpu_gnt", cpu_gnt, in_txn && own_cpu);
            chk("ldr_gnt", ldr_gnt, in_txn && !own_cpu);
            chk("cpu_done", cpu_done, e_done && own_cpu);
            chk("ldr_done", ldr_done, e_done && !own_cpu);
            chk("cpu_stall", cpu_stall, cpu_req && !(e_done && own_cpu));
            chk("ldr_stall", ldr_stall, ldr_req && !(e_done && !own_cpu));
            chk("mem_en", mem_en, e_men);
            chk("mem_we", mem_we, e_men && cur.we);
            if (e_men) begin
                chk("mem_addr", mem_addr, cur.addr);
                if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            if (e_done) begin
                if (cur.we)       ref_mem[cur.addr] = cur.wdata;
                else if (own_cpu) m_cpu_rd = ref_mem[cur.addr];
                else              m_ldr_rd = ref_mem[cur.addr];
                if (own_cpu) void'(cq.pop_front());
                else         void'(lq.pop_front());
            end
            chk("cpu_rdata", cpu_rdata, m_cpu_rd);
            chk("ldr_rdata", ldr_rdata, m_ldr_rd);
            @(posedge CLK);
            if (e_done) begin
                busy = 0;
            end else if (!busy && (cpu_req || ldr_req)) begin
                busy = 1; t_start = cyc;
                if (cpu_req && ldr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    own_cpu = !m_last_cpu;
`else
                    own_cpu = 1'b0;
`endif
                    m_last_cpu = own_cpu;
                end else begin
                    own_cpu = cpu_req;
                end
                cur   = own_cpu ? cq[0] : lq[0];
                t_lat = cur.we ? 2 : LAT + 1;
            end
            #1;
            drive(cpu_drop, busy, own_cpu);
            cyc++;
        end
        chk("round_in_budget", cyc < 200, 1);
        cq.delete(); lq.delete();
        cpu_req = 1'b0; ldr_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk("tail_cpu_gnt", cpu_gnt, 0);   chk("tail_ldr_gnt", ldr_gnt, 0);
            chk("tail_cpu_done", cpu_done, 0); chk("tail_ldr_done", ldr_done, 0);
            chk("tail_mem_en", mem_en, 0);
        end
    endtask

    // Single CPU transaction on the MEM_LAT=3 instance.
    task automatic b_txn(input logic we, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd);
        int lat;
        lat = we ? 2 : 4;
        @(posedge CLK); #1;
        b_cpu_req = 1'b1; b_cpu_we = we; b_cpu_addr = a; b_cpu_wdata = d;
        for (int c = 0; c <= lat + 2; c++) begin
            @(negedge CLK);
            chk("b_done", b_cpu_done, c == lat);
            chk("b_gnt", b_cpu_gnt, (c >= 1) && (c <= lat));
            chk("b_mem_en", b_mem_en, c == 1);
            chk("b_stall", b_cpu_stall, c < lat);
            if (c == 1) chk("b_mem_addr", b_mem_addr, a);
            if (c == lat && !we) chk("b_rdata", b_cpu_rdata, exp_rd);
            @(posedge CLK); #1;
            if (c == lat) b_cpu_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Loader loads 0xA5 at 0x10, then a CPU read of it.
        lq.push_back(mk(1'b1, 8'h10, 8'hA5));
        run_round(1'b0);
        cq.push_back(mk(1'b0, 8'h10, 8'h00));
        run_round(1'b0);
        chk("t1_cpu_rdata_a5", cpu_rdata, 8'hA5);

        // CPU write 0x3C to 0x20 and read back.
        cq.push_back(mk(1'b1, 8'h20, 8'h3C));
        cq.push_back(mk(1'b0, 8'h20, 8'h00));
        run_round(1'b0);
        chk("t2_readback_3c", cpu_rdata, 8'h3C);

        // CPU drops req while granted.
        cq.push_back(mk(1'b0, 8'h33, 8'h00));
        run_round(1'b1);

        // Simultaneous requests, two accesses each, from reset.
        do_reset();
        cq.push_back(mk(1'b0, 8'h01, 8'h00));
        cq.push_back(mk(1'b1, 8'h02, 8'h11));
        lq.push_back(mk(1'b1, 8'h03, 8'h22));
        lq.push_back(mk(1'b0, 8'h01, 8'h00));
        run_round(1'b0);

        // MEM_LAT=3: write, read back after 4 cycles, read of initial contents.
        b_txn(1'b1, 8'h20, 8'h3C, 8'h00);
        b_txn(1'b0, 8'h20, 8'h00, 8'h3C);
        b_txn(1'b0, 8'h42, 8'h00, init_val(8'h42));

        // Reset while in WAIT aborts without done.
        @(posedge CLK); #1;
        b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 8'h42;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b1; b_cpu_req = 1'b0;
        @(negedge CLK);
        chk("t6_in_wait_gnt", b_cpu_gnt, 1);
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("t6_gnt", b_cpu_gnt, 0);     chk("t6_done", b_cpu_done, 0);
            chk("t6_mem_en", b_mem_en, 0);   chk("t6_rdata", b_cpu_rdata, 0);
            chk("t6_mem_addr", b_mem_addr, 0);
        end
        b_txn(1'b0, 8'h42, 8'h00, init_val(8'h42));

        // Random traffic.
        for (int r = 0; r < 40; r++) begin
            int nc, nl;
            nc = $urandom_range(0, 3);
            nl = $urandom_range(0, 3);
            for (int k = 0; k < nc; k++) cq.push_back(rand_cmd());
            for (int k = 0; k < nl; k++) lq.push_back(rand_cmd());
            run_round($urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
